// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the ALU decoder / write-back path and muldiv_unit.
// The decoder side uses the master modport, the sequencer uses the slave modport.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             mult;
   logic             div;
   logic             movhi;
   logic             movlo;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic [WIDTH-1:0] hilo_out;
   logic             busy;
   logic             stall;
   logic             done;
   logic             divz;

   modport master (
      output mult, div, movhi, movlo, srca, srcb,
      input  hilo_out, busy, stall, done, divz
   );

   modport slave (
      input  mult, div, movhi, movlo, srca, srcb,
      output hilo_out, busy, stall, done, divz
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide sequencer owning the HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; without it only multiply exists.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef MULDIV_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
`endif

   state_t             state_reg;
   logic [CW-1:0]      count_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic               neg_reg;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic               last_step;

   assign mag_a     = bus.srca[WIDTH-1] ? -bus.srca : bus.srca;
   assign mag_b     = bus.srcb[WIDTH-1] ? -bus.srcb : bus.srcb;
   assign last_step = (count_reg == CW'(WIDTH - 1));

   // Multiplier sits in the low half of the accumulator and is consumed LSB first.
   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_reg[0] ? a_reg : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
   assign prod_fix = neg_reg ? -acc_reg : acc_reg;

`ifdef MULDIV_DIV_EN
   logic [WIDTH-1:0]   b_reg;
   logic               neg_rem_reg;
   logic               divz_reg;
   logic               op_div_reg;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Remainder in the high half, dividend shifting out / quotient shifting in the low half.
   assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, b_reg};
   assign div_next  = rem_diff[WIDTH]
                    ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                    : {rem_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};
   assign quo_fix   = neg_reg     ? -acc_reg[WIDTH-1:0]       : acc_reg[WIDTH-1:0];
   assign rem_fix   = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
`else
   logic unused_div;
   assign unused_div = bus.div;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         a_reg       <= '0;
         acc_reg     <= '0;
         neg_reg     <= 1'b0;
`ifdef MULDIV_DIV_EN
         b_reg       <= '0;
         neg_rem_reg <= 1'b0;
         divz_reg    <= 1'b0;
         op_div_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.mult) begin
                  a_reg      <= mag_a;
                  acc_reg    <= {{WIDTH{1'b0}}, mag_b};
                  neg_reg    <= bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
                  count_reg  <= '0;
                  state_reg  <= MUL;
`ifdef MULDIV_DIV_EN
                  op_div_reg <= 1'b0;
                  divz_reg   <= 1'b0;
               end else if (bus.div) begin
                  a_reg      <= bus.srca;
                  op_div_reg <= 1'b1;
                  if (bus.srcb == '0) begin
                     divz_reg  <= 1'b1;
                     state_reg <= FIX;
                  end else begin
                     divz_reg    <= 1'b0;
                     b_reg       <= mag_b;
                     acc_reg     <= {{WIDTH{1'b0}}, mag_a};
                     neg_reg     <= bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
                     neg_rem_reg <= bus.srca[WIDTH-1];
                     count_reg   <= '0;
                     state_reg   <= DIV;
                  end
`endif
               end
            end
            MUL: begin
               acc_reg   <= mul_next;
               count_reg <= count_reg + 1'b1;
               if (last_step) state_reg <= FIX;
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
               acc_reg   <= div_next;
               count_reg <= count_reg + 1'b1;
               if (last_step) state_reg <= FIX;
            end
`endif
            FIX: begin
`ifdef MULDIV_DIV_EN
               if (divz_reg) begin
                  hi_reg <= a_reg;
                  lo_reg <= '1;
               end else if (op_div_reg) begin
                  hi_reg <= rem_fix;
                  lo_reg <= quo_fix;
               end else begin
                  {hi_reg, lo_reg} <= prod_fix;
               end
`else
               {hi_reg, lo_reg} <= prod_fix;
`endif
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy     = (state_reg != IDLE);
   assign bus.done     = (state_reg == FIX);
   assign bus.hilo_out = bus.movhi ? hi_reg : lo_reg;
`ifdef MULDIV_DIV_EN
   assign bus.divz     = (state_reg == FIX) & divz_reg;
   assign bus.stall    = bus.busy & (bus.mult | bus.div | bus.movhi | bus.movlo);
`else
   assign bus.divz     = 1'b0;
   assign bus.stall    = bus.busy & (bus.mult | bus.movhi | bus.movlo);
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a transaction-level HI/LO model.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_unit;
   localparam int W = 32;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus ();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int divz_cnt = 0;

   // Model: committed HI/LO, cycles of busy remaining, and the result waiting to commit.
   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int           m_cnt = 0;
   bit           m_divz = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : model
      logic [63:0] pr;
      longint pa, pb, q, r;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_cnt = 0; m_hi = '0; m_lo = '0; m_divz = 1'b0;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
         end else if (bus.mult) begin
            pa = longint'($signed(bus.srca));
            pb = longint'($signed(bus.srcb));
            pr = 64'(pa * pb);
            p_hi = pr[63:32]; p_lo = pr[31:0];
            m_cnt = W + 1; m_divz = 1'b0;
            $display("mult %h * %h -> hi %h lo %h", bus.srca, bus.srcb, p_hi, p_lo);
         end else if (DIV_EN && bus.div) begin
            if (bus.srcb == '0) begin
               p_hi = bus.srca; p_lo = '1; m_cnt = 1; m_divz = 1'b1;
            end else begin
               pa = longint'($signed(bus.srca));
               pb = longint'($signed(bus.srcb));
               q = pa / pb; r = pa % pb;
               pr = 64'(q); p_lo = pr[31:0];
               pr = 64'(r); p_hi = pr[31:0];
               m_cnt = W + 1; m_divz = 1'b0;
            end
            $display("div  %h / %h -> hi %h lo %h", bus.srca, bus.srcb, p_hi, p_lo);
         end
      end
   end

   initial begin : compare
      bit exp_busy, exp_done;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_cnt = 0; m_hi = '0; m_lo = '0; m_divz = 1'b0;
         end
         exp_busy = (m_cnt > 0);
         exp_done = (m_cnt == 1);
         chk("busy", 32'(bus.busy), 32'(exp_busy));
         chk("done", 32'(bus.done), 32'(exp_done));
         chk("divz", 32'(bus.divz), 32'(exp_done && m_divz));
         chk("stall", 32'(bus.stall),
             32'(exp_busy && (bus.mult || bus.movhi || bus.movlo || (DIV_EN && bus.div))));
         chk("hilo_out", bus.hilo_out, bus.movhi ? m_hi : m_lo);
         if (bus.done) done_cnt++;
         if (bus.divz) divz_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.mult = m; bus.div = d; bus.srca = a; bus.srcb = b;
      step();
      bus.mult = 1'b0; bus.div = 1'b0;
      bus.srca = $urandom; bus.srcb = $urandom;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         step();
      end
      chk("busy_bound", 32'(bus.busy), 32'd0);
   endtask

   task automatic read(input bit h, input logic [W-1:0] exp, input string name);
      bus.movhi = h; bus.movlo = !h;
      #1;
      chk(name, bus.hilo_out, exp);
      bus.movhi = 1'b0; bus.movlo = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin : timeout
      #1_000_000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "bench did not terminate");
   end

   initial begin : stim
      int n, d0, z0;
      reset = 1'b1;
      bus.mult = 1'b0; bus.div = 1'b0; bus.movhi = 1'b0; bus.movlo = 1'b0;
      bus.srca = '0; bus.srcb = '0;
      step(); step(); step();
      reset = 1'b0;
      read(1'b1, 32'h0, "reset_hi");
      read(1'b0, 32'h0, "reset_lo");

      d0 = done_cnt;
      start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      wait_idle(n);
      chk("mul_busy_len", 32'(n), 32'd33);
      chk("mul_done_pulses", 32'(done_cnt - d0), 32'd1);
      read(1'b1, 32'hFFFF_FFFF, "mul_7x-3_hi");
      read(1'b0, 32'hFFFF_FFEB, "mul_7x-3_lo");
      chk("model_7x-3_lo", m_lo, 32'hFFFF_FFEB);

`ifdef MULDIV_DIV_EN
      start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      chk("div_busy_len", 32'(n), 32'd33);
      read(1'b0, 32'hFFFF_FFFD, "div_-7/2_lo");
      read(1'b1, 32'hFFFF_FFFF, "div_-7/2_hi");
      start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      read(1'b0, 32'h8000_0000, "div_ovf_lo");
      read(1'b1, 32'h0, "div_ovf_hi");
      z0 = divz_cnt;
      start(1'b0, 1'b1, 32'h1234_5678, 32'h0);
      wait_idle(n);
      chk("divz_busy_len", 32'(n), 32'd1);
      chk("divz_pulses", 32'(divz_cnt - z0), 32'd1);
      read(1'b1, 32'h1234_5678, "divz_hi");
      read(1'b0, 32'hFFFF_FFFF, "divz_lo");
`else
      z0 = divz_cnt;
      start(1'b0, 1'b1, 32'd10, 32'd2);
      wait_idle(n);
      chk("nodiv_busy_len", 32'(n), 32'd0);
      chk("nodiv_divz", 32'(divz_cnt - z0), 32'd0);
      read(1'b1, 32'hFFFF_FFFF, "nodiv_hi_kept");
      read(1'b0, 32'hFFFF_FFEB, "nodiv_lo_kept");
`endif

      // mflo and a second mult arrive mid-multiply; neither may restart or leak through.
      start(1'b1, 1'b0, 32'd5, 32'd6);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         if (n == 5) begin bus.movlo = 1'b1; bus.mult = 1'b1; bus.srca = $urandom; end
         if (n == 10) bus.mult = 1'b0;
         step();
      end
      chk("stall_busy_len", 32'(n), 32'd33);
      #1;
      chk("stall_released", 32'(bus.stall), 32'd0);
      chk("stall_new_lo", bus.hilo_out, 32'd30);
      bus.movlo = 1'b0;
      $display("mflo during mult 5*6 -> lo %h after %0d busy cycles", bus.hilo_out, n);

      d0 = done_cnt;
      start(1'b1, 1'b0, 32'd9, 32'd9);
      repeat (9) step();
      reset = 1'b1;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_hilo", bus.hilo_out, 32'd0);
      step();
      reset = 1'b0;
      repeat (40) step();
      chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
      start(1'b1, 1'b0, 32'd3, 32'd4);
      wait_idle(n);
      read(1'b0, 32'd12, "post_rst_lo");
      read(1'b1, 32'd0, "post_rst_hi");

      for (int i = 0; i < 1500; i++) begin
         bus.mult  = ($urandom_range(0, 15) == 0);
         bus.div   = ($urandom_range(0, 15) == 0);
         bus.movhi = ($urandom_range(0, 3) == 0);
         bus.movlo = ($urandom_range(0, 3) == 0);
         bus.srca  = pick();
         bus.srcb  = pick();
         reset     = ($urandom_range(0, 399) == 0);
         step();
      end
      bus.mult = 1'b0; bus.div = 1'b0; bus.movhi = 1'b0; bus.movlo = 1'b0;
      reset = 1'b0;
      step();
      wait_idle(n);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
